// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NREQ requesters,
// with a per-requester lock that grants one requester back-to-back exclusive access.
module regbank_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ-1:0]      Lock,
  input  logic [NREQ*AW-1:0]   Addr,
  input  logic [NREQ*DW-1:0]   Data,
  output logic [NREQ-1:0]      Ack,
  output logic                 WE,
  output logic [AW-1:0]        WAddr,
  output logic [DW-1:0]        WData,
  output logic                 Busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   own_q, own_d;
  logic            own_v_q, own_v_d;
  logic            we_q, we_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [PW-1:0]   win;
  logic            grant;
  logic [PW-1:0]   gidx;

  // Round-robin search: first requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && Req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    own_v_d = own_v_q;
    we_d    = 1'b0;
    ack_d   = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    grant   = 1'b0;
    gidx    = win;

    case (state_q)
      IDLE: begin
        if (own_v_q && Lock[own_q]) begin
          // Locked owner: everyone else is starved until the lock drops.
          if (Req[own_q]) begin
            grant = 1'b1;
            gidx  = own_q;
          end
        end else begin
          own_v_d = 1'b0;
          if (found) begin
            grant = 1'b1;
            gidx  = win;
          end
        end

        if (grant) begin
          state_d = ISSUE;
          we_d    = 1'b1;
          waddr_d = Addr[int'(gidx)*AW +: AW];
          wdata_d = Data[int'(gidx)*DW +: DW];
          ack_d   = NREQ'(1) << gidx;
          ptr_d   = gidx;
          if (Lock[gidx]) begin
            own_v_d = 1'b1;
            own_d   = gidx;
          end
        end
      end

      ISSUE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ISSUE) || own_v_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      own_q   <= '0;
      own_v_q <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      own_v_q <= own_v_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign Ack   = ack_q;
  assign WE    = we_q;
  assign WAddr = waddr_q;
  assign WData = wdata_q;
  assign Busy  = busy_q;

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares one write port of a bank of 32-bit enable-gated registers among NREQ requesters.
- Arbitrates pending write requests round-robin and drives a registered write-enable/address/data triple to the bank.
- Returns a one-cycle Ack to the served requester.
- Supports a Lock mode that gives one requester back-to-back exclusive access for burst updates.

Parameters:
- NREQ, 4: number of requesters (2..8).
- AW, 5: register-address width.
- DW, 32: data width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  NREQ  per-requester write request; level, held until Ack.
- Lock  in  NREQ  per-requester lock; sampled with Req at grant.
- Addr  in  NREQ*AW  per-requester target address; slice i = [i*AW +: AW].
- Data  in  NREQ*DW  per-requester write data; slice i = [i*DW +: DW].
- Ack  out  NREQ  one-hot, one-cycle pulse; write issued for requester i.
- WE  out  1  write enable to register bank.
- WAddr  out  AW  write address to bank.
- WData  out  DW  write data to bank.
- Busy  out  1  high in ISSUE state or while a lock owner exists.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; WE=0; Ack=0; WAddr=0; WData=0; Busy=0.
  - Pointer Ptr=NREQ-1, so requester 0 is first in priority after reset.
  - Lock owner cleared.
- FSM has two states, IDLE and ISSUE. All outputs are registered.
- IDLE, no lock owner:
  - Candidates are all i with Req[i]=1.
  - Winner is the first candidate searching Ptr+1, Ptr+2, ... modulo NREQ.
  - If a winner w exists, at the clock edge:
    - state←ISSUE; WE←1; WAddr←Addr[w]; WData←Data[w]; Ack←one-hot(w); Ptr←w.
    - If Lock[w]=1, owner←w.
  - No candidates: remain in IDLE, outputs 0.
- IDLE, owner o valid:
  - If Lock[o]=0, the owner is released and normal arbitration runs in the same cycle.
  - If Lock[o]=1 and Req[o]=1, grant o regardless of other requests.
  - If Lock[o]=1 and Req[o]=0, wait; others are starved.
- ISSUE:
  - Exactly one cycle; no arbitration.
  - Next edge: state←IDLE; WE←0; Ack←0. WAddr and WData hold their last values.
  - Requester must drop Req or present new Addr/Data by the edge ending the ISSUE cycle.
- Latency: Req sampled at edge k gives WE=1 and Ack in cycle k+1.
- Maximum throughput is one write per 2 cycles.
- WE and Ack are never high for more than one consecutive cycle.
- At most one Ack bit is set at any time.
- Req dropped before being granted: no write, no Ack; the pointer is unaffected.
- Reset asserted mid-ISSUE: WE and Ack clear immediately; the write is not guaranteed.
  - After release, arbitration restarts from requester 0.
- No address filtering: all addresses, including 0, are written.

Test Plan:
- Reset check: Reset=0 with Req=4'b1111 → WE=0, Ack=0, WAddr=0, WData=0, Busy=0 throughout. After release, first Ack=4'b0001.
- Single requester: Req[2]=1, Addr2=5'd7, Data2=32'hDEAD_BEEF held one cycle after Ack → exactly one WE pulse with WAddr=7, WData=DEADBEEF, Ack=4'b0100. Busy high only in that cycle.
- All four request simultaneously from reset, each dropping on its Ack → Ack order 0001, 0010, 0100, 1000. WE high on cycles 1, 3, 5, 7 after the first edge; WE low in between.
- Fairness rotation: after requester 1 is served, Req=4'b1011 → next grant goes to 3, then 0, then 1.
- Lock burst with requester 3 holding Lock:
  - Requester 3 issues 3 writes (Addr 1, 2, 3; Data 32'h1, 32'h2, 32'h3) while Req[0]=1 continuously.
  - Required: three consecutive Ack=1000, then requester 0 is served once Lock[3] drops; Busy stays high throughout the burst.
- Async reset mid-ISSUE: assert Reset between edges while WE=1 → WE and Ack go 0 before the next edge. Post-reset grant starts at requester 0.
